// File: rtl/muon_pkg.sv
// rtl/muon_pkg.sv - shared types and sizes for the muon test-pulse generator
//
// Purpose: timing/channel widths, run-state enum, latched config struct,
//          saturating increment helper.
package muon_pkg;

  localparam int CNT_W = 16;  // width of all timing counters and config fields
  localparam int N_CH  = 8;   // number of output lines on connector C

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] skew;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] burst_count;
    logic [N_CH-1:0]  mask_a;
    logic [N_CH-1:0]  mask_b;
  } cfg_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/muon_pulse_gen_if.sv
// rtl/muon_pulse_gen_if.sv - control/config/output bundle of the pulse generator
//
// Purpose: groups the run controls, configuration and pulse outputs.
// slave  : generator side (controls/config in, C/status out)
// master : controller side (controls/config out, C/status in)
interface muon_pulse_gen_if;
  import muon_pkg::*;

  logic             start;
  logic             stop;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] skew;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] burst_count;
  logic [N_CH-1:0]  mask_a;
  logic [N_CH-1:0]  mask_b;
  logic [N_CH-1:0]  C;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic [CNT_W-1:0] pulses_sent;

  modport slave (
    input  start, stop, width, skew, period, burst_count, mask_a, mask_b,
    output C, busy, done, cfg_err, pulses_sent
  );

  modport master (
    output start, stop, width, skew, period, burst_count, mask_a, mask_b,
    input  C, busy, done, cfg_err, pulses_sent
  );

endinterface

// File: rtl/muon_period_timer.sv
// rtl/muon_period_timer.sv - period timebase t with wrap detection
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : force t to 0 (run start)
//   en_i        : advance t by one this cycle
//   period_i    : cycles per period (non-zero whenever en_i is high)
//   t_o         : current position within the period
//   wrap_o      : t is at period-1 and advancing, so it returns to 0 next
module muon_period_timer
  import muon_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] period_i,
  output logic [CNT_W-1:0] t_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] t_q, t_d;

  assign wrap_o = en_i && (t_q == period_i - CNT_W'(1));
  assign t_o    = t_q;

  always_comb begin
    t_d = t_q;
    if (load_i) begin
      t_d = '0;
    end else if (en_i) begin
      t_d = wrap_o ? '0 : t_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q <= '0;
    end else begin
      t_q <= t_d;
    end
  end

endmodule

// File: rtl/muon_pulse_gen.sv
// rtl/muon_pulse_gen.sv - test-pulse transmitter for the coincidence front end
//
// Ports:
//   ACLK0 : system clock
//   RST_N : asynchronous active-low reset
//   bus   : slave side of muon_pulse_gen_if (start/stop, config, C, busy,
//           done, cfg_err, pulses_sent)
// Group A fires at t < width, group B at skew <= t < skew+width, both within
// one period. C is registered, so it shows the previous cycle's t.
module muon_pulse_gen
  import muon_pkg::*;
(
  input  logic                  ACLK0,
  input  logic                  RST_N,
  muon_pulse_gen_if.slave       bus
);

  state_e           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [N_CH-1:0]  c_q, c_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] sent_q, sent_d;

  logic             accept;
  logic             running;
  logic [CNT_W-1:0] t;
  logic             wrap;
  logic             act_a, act_b;
  logic [CNT_W:0]   skew_end;
  logic [CNT_W-1:0] sent_inc;
  logic             end_run;

  assign running = (state_q != IDLE);

  muon_period_timer u_timer (
    .clk      (ACLK0),
    .rst_n    (RST_N),
    .load_i   (accept),
    .en_i     (running),
    .period_i (cfg_q.period),
    .t_o      (t),
    .wrap_o   (wrap)
  );

  // One extra bit so skew+width near all-ones cannot wrap around.
  assign skew_end = {1'b0, cfg_q.skew} + {1'b0, cfg_q.width};
  assign act_a    = (t < cfg_q.width);
  assign act_b    = (t >= cfg_q.skew) && ({1'b0, t} < skew_end);
  assign sent_inc = sat_inc(sent_q);

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    sent_d  = sent_q;
    c_d     = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    accept  = 1'b0;
    end_run = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.period != '0) begin
            accept  = 1'b1;
            cfg_d   = '{width: bus.width, skew: bus.skew, period: bus.period,
                        burst_count: bus.burst_count, mask_a: bus.mask_a,
                        mask_b: bus.mask_b};
            sent_d  = '0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN, STOPPING: begin
        c_d = ({N_CH{act_a}} & cfg_q.mask_a) | ({N_CH{act_b}} & cfg_q.mask_b);
        if (wrap) begin
          sent_d  = sent_inc;
          // A stop sampled on a wrap cycle ends the run at that period boundary.
          end_run = (state_q == STOPPING) || bus.stop ||
                    ((cfg_q.burst_count != '0) && (sent_inc == cfg_q.burst_count));
        end
        if (end_run) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (state_q == RUN && bus.stop) begin
          state_d = STOPPING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK0 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      c_q     <= c_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sent_q  <= sent_d;
    end
  end

  assign bus.C           = c_q;
  assign bus.busy        = running;
  assign bus.done        = done_q;
  assign bus.cfg_err     = err_q;
  assign bus.pulses_sent = sent_q;

endmodule

// File: tb/tb_muon_pulse_gen.sv
// tb/tb_muon_pulse_gen.sv - self-checking bench for muon_pulse_gen
module tb_muon_pulse_gen;
  import muon_pkg::*;

  logic ACLK0 = 1'b0;
  logic RST_N = 1'b0;
  always #5 ACLK0 = ~ACLK0;

  muon_pulse_gen_if bus ();

  muon_pulse_gen dut (
    .ACLK0 (ACLK0),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [N_CH-1:0] c;
    logic            busy;
    logic            done;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Closed-form expectation: start sampled at edge 1, run ends with done at
  // cycle e; C at cycle n reflects t = (n-2) mod period for 2 <= n <= e.
  function automatic exp_t model(input cfg_t c, input int n, input int e);
    exp_t r;
    int   t, w, s;
    r.c    = '0;
    r.busy = (n >= 1) && (n <= e - 1);
    r.done = (n == e);
    if (n >= 2 && n <= e) begin
      t = (n - 2) % int'(c.period);
      w = int'(c.width);
      s = int'(c.skew);
      if (t < w) r.c = r.c | c.mask_a;
      if (t >= s && t < s + w) r.c = r.c | c.mask_b;
    end
    return r;
  endfunction

  task automatic drive_cfg(input cfg_t c);
    bus.width       = c.width;
    bus.skew        = c.skew;
    bus.period      = c.period;
    bus.burst_count = c.burst_count;
    bus.mask_a      = c.mask_a;
    bus.mask_b      = c.mask_b;
  endtask

  // Called at a negedge; drives start in cycle 0 and checks cycles 1..e+1.
  task automatic run(input string tag, input cfg_t c, input int e,
                     input int stop_cyc, input int poke_cyc);
    exp_t got;
    drive_cfg(c);
    bus.start = 1'b1;
    for (int n = 1; n <= e + 1; n++) sb.push_back(model(c, n, e));
    for (int n = 1; n <= e + 1; n++) begin
      @(posedge ACLK0);
      @(negedge ACLK0);
      bus.start = (n == poke_cyc);
      bus.stop  = (n == stop_cyc);
      if (n == poke_cyc) begin
        bus.width = 16'd7; bus.period = 16'd3; bus.mask_a = 8'hFF; bus.burst_count = 16'd0;
      end
      got = sb.pop_front();
      check($sformatf("%s_C@%0d", tag, n), 32'(bus.C), 32'(got.c));
      check($sformatf("%s_busy@%0d", tag, n), 32'(bus.busy), 32'(got.busy));
      check($sformatf("%s_done@%0d", tag, n), 32'(bus.done), 32'(got.done));
    end
  endtask

  initial begin
    cfg_t c;
    bus.start = 1'b0; bus.stop = 1'b0;
    c = '0;
    drive_cfg(c);

    // reset state
    #2;
    check("rst_C", 32'(bus.C), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_err", 32'(bus.cfg_err), 32'h0);
    check("rst_sent", 32'(bus.pulses_sent), 32'h0);
    @(negedge ACLK0);
    @(negedge ACLK0);
    RST_N = 1'b1;
    @(negedge ACLK0);

    // config error: period==0
    c = '{width: 16'd3, skew: 16'd0, period: 16'd0, burst_count: 16'd1, mask_a: 8'h01, mask_b: 8'h02};
    drive_cfg(c);
    bus.start = 1'b1;
    @(posedge ACLK0); @(negedge ACLK0);
    bus.start = 1'b0;
    check("err_pulse", 32'(bus.cfg_err), 32'h1);
    check("err_busy", 32'(bus.busy), 32'h0);
    check("err_C", 32'(bus.C), 32'h0);
    @(posedge ACLK0); @(negedge ACLK0);
    check("err_clear", 32'(bus.cfg_err), 32'h0);
    check("err_busy2", 32'(bus.busy), 32'h0);

    // async reset mid-run
    c = '{width: 16'd3, skew: 16'd0, period: 16'd3, burst_count: 16'd4, mask_a: 8'h01, mask_b: 8'h02};
    drive_cfg(c);
    bus.start = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(posedge ACLK0); @(negedge ACLK0);
      bus.start = 1'b0;
    end
    check("pre_rst_C", 32'(bus.C), 32'h03);
    check("pre_rst_sent", 32'(bus.pulses_sent), 32'h1);
    #2 RST_N = 1'b0;
    #1;
    check("async_C", 32'(bus.C), 32'h0);
    check("async_busy", 32'(bus.busy), 32'h0);
    check("async_sent", 32'(bus.pulses_sent), 32'h0);
    for (int n = 0; n < 2; n++) begin
      @(posedge ACLK0); @(negedge ACLK0);
      check("async_nodone", 32'(bus.done), 32'h0);
    end
    RST_N = 1'b1;
    @(negedge ACLK0);

    // single burst
    c = '{width: 16'd3, skew: 16'd0, period: 16'd10, burst_count: 16'd2, mask_a: 8'h01, mask_b: 8'h02};
    run("burst", c, 21, -1, -1);
    check("burst_sent", 32'(bus.pulses_sent), 32'h2);

    // skewed pair, with a start and config change mid-run that must be ignored
    c = '{width: 16'd2, skew: 16'd4, period: 16'd8, burst_count: 16'd1, mask_a: 8'h01, mask_b: 8'h80};
    run("skew", c, 9, -1, 4);
    check("skew_sent", 32'(bus.pulses_sent), 32'h1);
    check("skew_idle", 32'(bus.busy), 32'h0);

    // truncation of B at period end
    c = '{width: 16'd4, skew: 16'd6, period: 16'd8, burst_count: 16'd1, mask_a: 8'h00, mask_b: 8'h04};
    run("trunc", c, 9, -1, -1);
    check("trunc_C_after", 32'(bus.C), 32'h0);

    // continuous plus stop in second period
    c = '{width: 16'd2, skew: 16'd1, period: 16'd5, burst_count: 16'd0, mask_a: 8'h01, mask_b: 8'h02};
    run("stop", c, 11, 7, -1);
    check("stop_sent", 32'(bus.pulses_sent), 32'h2);

    // stop in IDLE is ignored
    bus.stop = 1'b1;
    @(posedge ACLK0); @(negedge ACLK0);
    bus.stop = 1'b0;
    check("idle_stop_busy", 32'(bus.busy), 32'h0);
    check("idle_stop_done", 32'(bus.done), 32'h0);
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
